// File: rtl/fir_disp_pkg.sv
// Shared types and elaboration-time helpers for the serial FIR display front-end.
package fir_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        BCD  = 2'd2
    } state_t;

    localparam logic [3:0] BLANK = 4'hF;

    // Decimal digits needed to show the largest value of a bin_w-bit unsigned number.
    function automatic int bcd_digits(input int bin_w);
        longint v;
        int     n;
        v = (64'sd1 << bin_w) - 64'sd1;
        n = 32'sd1;
        v = v / 64'sd10;
        while (v > 64'sd0) begin
            v = v / 64'sd10;
            n = n + 32'sd1;
        end
        return n;
    endfunction

    function automatic longint pow10(input int n);
        longint r;
        r = 64'sd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'sd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one add-3/shift step per clock, BIN_W steps per conversion.
module bin2bcd_serial
    import fir_disp_pkg::*;
#(
    parameter int BIN_W = 10,
    parameter int BCD_D = bcd_digits(BIN_W)
) (
    input  logic                 clk_1kHz,
    input  logic                 i_rst_n,
    input  logic                 start,
    input  logic [BIN_W-1:0]     bin,
    output logic                 done,
    output logic [BCD_D*4-1:0]   bcd
);

    localparam int SR_W = BCD_D * 4 + BIN_W;
    localparam int CW   = $clog2(BIN_W + 1);

    function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] t;
        t = v;
        for (int d = 0; d < BCD_D; d++) begin
            if (t[BIN_W + d*4 +: 4] >= 4'd5) begin
                t[BIN_W + d*4 +: 4] = t[BIN_W + d*4 +: 4] + 4'd3;
            end
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    logic [SR_W-1:0] sr_r;
    logic [SR_W-1:0] step_in_s;
    logic [SR_W-1:0] step_out_s;
    logic [CW-1:0]   cnt_r;
    logic            busy_r;

    // The start edge performs the first step directly on the freshly loaded operand.
    always_comb begin
        step_in_s = sr_r;
        if (start) begin
            step_in_s = {{(BCD_D*4){1'b0}}, bin};
        end else begin
            step_in_s = sr_r;
        end
        step_out_s = dd_step(step_in_s);
    end

    // Shift register, step counter and one-cycle done pulse.
    always_ff @(posedge clk_1kHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr_r   <= {SR_W{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr_r   <= step_out_s;
                cnt_r  <= CW'(1);
                busy_r <= 1'b1;
            end else if (busy_r) begin
                sr_r  <= step_out_s;
                cnt_r <= cnt_r + CW'(1);
                if (cnt_r == CW'(BIN_W - 1)) begin
                    busy_r <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    assign bcd = sr_r[SR_W-1 -: BCD_D*4];

endmodule

// File: rtl/fir_serial_disp.sv
// Time-shared single-MAC FIR with sample handshake, serial BCD conversion and a
// multiplexed digit scanner; all logic runs from the 1 kHz divider clock.
module fir_serial_disp
    import fir_disp_pkg::*;
#(
    parameter int                     DATA_W     = 3,
    parameter int                     TAPS       = 8,
    parameter int                     COEF_W     = 4,
    parameter logic [TAPS*COEF_W-1:0] COEFS      = {4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd3, 4'd2, 4'd1},
    parameter int                     NUM_DIGITS = 4,
    localparam int                    ACC_W      = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                  clk_1kHz,
    input  logic                  i_rst_n,
    input  logic                  i_mode,
    input  logic                  i_sample_valid,
    input  logic [DATA_W-1:0]     i_sample,
    output logic                  o_sample_ready,
    output logic                  o_busy,
    output logic                  o_y_valid,
    output logic [ACC_W-1:0]      o_y,
    output logic                  o_overflow,
    output logic [NUM_DIGITS-1:0] o_cs,
    output logic [3:0]            o_digit
);

    localparam int          KW    = $clog2(TAPS);
    localparam int          BCD_D = bcd_digits(ACC_W);
    localparam int          PAD_W = ((NUM_DIGITS > BCD_D) ? NUM_DIGITS : BCD_D) * 4;
    localparam logic [63:0] LIMIT = 64'(pow10(NUM_DIGITS) - 64'sd1);

    state_t                 state_r, next_s;
    logic [DATA_W-1:0]      x_r [TAPS];
    logic [ACC_W-1:0]       acc_r;
    logic [KW-1:0]          k_r;
    logic                   mode_r;
    logic                   bcd_start_r;
    logic                   bcd_done_s;
    logic [BCD_D*4-1:0]     bcd_s;
    logic [PAD_W-1:0]       bcd_pad_s;
    logic [COEF_W-1:0]      coef_s;
    logic [ACC_W-1:0]       prod_s;
    logic                   ovf_s;
    logic                   seen_s;
    logic [3:0]             dig_s;
    logic [3:0]             disp_s [NUM_DIGITS];
    logic [3:0]             disp_r [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]  cs_r;
    logic [3:0]             digit_s;

    bin2bcd_serial #(
        .BIN_W (ACC_W),
        .BCD_D (BCD_D)
    ) u_bcd (
        .clk_1kHz (clk_1kHz),
        .i_rst_n  (i_rst_n),
        .start    (bcd_start_r),
        .bin      (acc_r),
        .done     (bcd_done_s),
        .bcd      (bcd_s)
    );

    // State register.
    always_ff @(posedge clk_1kHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE:    if (i_sample_valid) next_s = MAC; else next_s = IDLE;
            MAC:     if (k_r == KW'(TAPS - 1)) next_s = BCD; else next_s = MAC;
            BCD:     if (bcd_done_s) next_s = IDLE; else next_s = BCD;
            default: next_s = IDLE;
        endcase
    end

    assign o_sample_ready = (state_r == IDLE);
    assign o_busy         = (state_r != IDLE);

    // Coefficient select and product for the tap addressed by k_r.
    always_comb begin
        coef_s = {COEF_W{1'b0}};
        if (mode_r) begin
            coef_s = {{(COEF_W-1){1'b0}}, 1'b1};
        end else begin
            coef_s = COEFS[k_r*COEF_W +: COEF_W];
        end
        prod_s = ACC_W'(x_r[k_r]) * ACC_W'(coef_s);
    end

    // Overflow saturation and leading-zero blanking of the converted result.
    always_comb begin
        bcd_pad_s = PAD_W'(bcd_s);
        ovf_s     = (64'(acc_r) > LIMIT);
        seen_s    = 1'b0;
        dig_s     = 4'd0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            dig_s = bcd_pad_s[i*4 +: 4];
            if (ovf_s) begin
                disp_s[i] = 4'd9;
            end else if (seen_s || (dig_s != 4'd0) || (i == 0)) begin
                seen_s    = 1'b1;
                disp_s[i] = dig_s;
            end else begin
                disp_s[i] = BLANK;
            end
        end
    end

    // Delay line, MAC accumulator and result/display registers.
    always_ff @(posedge clk_1kHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                x_r[i] <= {DATA_W{1'b0}};
            end
            acc_r       <= {ACC_W{1'b0}};
            k_r         <= {KW{1'b0}};
            mode_r      <= 1'b0;
            bcd_start_r <= 1'b0;
            o_y         <= {ACC_W{1'b0}};
            o_y_valid   <= 1'b0;
            o_overflow  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                disp_r[i] <= (i == 0) ? 4'd0 : BLANK;
            end
        end else begin
            o_y_valid   <= 1'b0;
            bcd_start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_sample_valid) begin
                        for (int i = TAPS - 1; i > 0; i--) begin
                            x_r[i] <= x_r[i-1];
                        end
                        x_r[0] <= i_sample;
                        mode_r <= i_mode;
                        acc_r  <= {ACC_W{1'b0}};
                        k_r    <= {KW{1'b0}};
                    end
                end
                MAC: begin
                    acc_r <= acc_r + prod_s;
                    k_r   <= k_r + KW'(1);
                    if (k_r == KW'(TAPS - 1)) begin
                        bcd_start_r <= 1'b1;
                    end
                end
                BCD: begin
                    if (bcd_done_s) begin
                        o_y        <= acc_r;
                        o_y_valid  <= 1'b1;
                        o_overflow <= ovf_s;
                        disp_r     <= disp_s;
                    end
                end
                default: begin
                    acc_r <= {ACC_W{1'b0}};
                end
            endcase
        end
    end

    // Digit scanner rotates every clock regardless of filter activity.
    always_ff @(posedge clk_1kHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cs_r <= NUM_DIGITS'(1);
        end else begin
            cs_r <= {cs_r[NUM_DIGITS-2:0], cs_r[NUM_DIGITS-1]};
        end
    end

    assign o_cs = cs_r;

    // Digit mux for the currently selected position.
    always_comb begin
        digit_s = BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cs_r[i]) begin
                digit_s = disp_r[i];
            end else begin
                digit_s = digit_s;
            end
        end
    end

    assign o_digit = digit_s;

endmodule

// File: tb/tb_fir_serial_disp.sv
// Scoreboard bench: a 4-digit and a 2-digit instance share stimulus; expected
// results are pushed on acceptance and compared when the output pulse is due.
module tb_fir_serial_disp;

    localparam logic [3:0] BLK = 4'hF;
    localparam int         LAT = 19;

    logic       clk_1kHz = 1'b0;
    logic       i_rst_n;
    logic       i_mode;
    logic       i_sample_valid;
    logic [2:0] i_sample;

    logic       rdy_a, busy_a, yv_a, ovf_a;
    logic [9:0] y_a;
    logic [3:0] cs_a, dig_a;
    logic       rdy_b, busy_b, yv_b, ovf_b;
    logic [9:0] y_b;
    logic [1:0] cs_b;
    logic [3:0] dig_b;

    always #5 clk_1kHz = ~clk_1kHz;

    fir_serial_disp dut_a (
        .clk_1kHz(clk_1kHz), .i_rst_n(i_rst_n), .i_mode(i_mode),
        .i_sample_valid(i_sample_valid), .i_sample(i_sample),
        .o_sample_ready(rdy_a), .o_busy(busy_a), .o_y_valid(yv_a), .o_y(y_a),
        .o_overflow(ovf_a), .o_cs(cs_a), .o_digit(dig_a)
    );

    fir_serial_disp #(.NUM_DIGITS(2)) dut_b (
        .clk_1kHz(clk_1kHz), .i_rst_n(i_rst_n), .i_mode(i_mode),
        .i_sample_valid(i_sample_valid), .i_sample(i_sample),
        .o_sample_ready(rdy_b), .o_busy(busy_b), .o_y_valid(yv_b), .o_y(y_b),
        .o_overflow(ovf_b), .o_cs(cs_b), .o_digit(dig_b)
    );

    typedef struct {
        int y;
        int c;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   coef[8] = '{1, 2, 3, 4, 4, 3, 2, 1};

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] mk_disp(input int y, input int nd);
        logic [15:0] r;
        int          v;
        bit          seen;
        r = 16'hFFFF;
        if (y > (10 ** nd) - 1) begin
            for (int i = 0; i < nd; i++) r[i*4 +: 4] = 4'd9;
            return r;
        end
        v = y;
        for (int i = 0; i < nd; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        seen = 1'b0;
        for (int i = nd - 1; i >= 0; i--) begin
            if (seen || r[i*4 +: 4] != 4'd0 || i == 0) seen = 1'b1;
            else r[i*4 +: 4] = BLK;
        end
        return r;
    endfunction

    int          cyc = 0;
    int          hist[8];
    int          cs_pos = 0;
    bit          prev_rst = 1'b0;
    bit          pend = 1'b0;
    int          pend_s, pend_m;
    logic [15:0] disp_a = 16'hFFF0;
    logic [15:0] disp_b = 16'hFFF0;

    always @(negedge clk_1kHz) begin : monitor
        int   y;
        bit   ev;
        exp_t e;
        cyc++;
        if (!i_rst_n) begin
            foreach (hist[k]) hist[k] = 0;
            q.delete();
            pend     = 1'b0;
            cs_pos   = 0;
            prev_rst = 1'b0;
            disp_a   = 16'hFFF0;
            disp_b   = 16'hFFF0;
            chk("rst_cs", cs_a, 1);
            chk("rst_valid", yv_a, 0);
        end else begin
            if (prev_rst) cs_pos = (cs_pos + 1) % 4;
            prev_rst = 1'b1;
            if (pend) begin
                for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = pend_s;
                y = 0;
                for (int k = 0; k < 8; k++) y += hist[k] * (pend_m != 0 ? 1 : coef[k]);
                e.y = y;
                e.c = cyc;
                q.push_back(e);
            end
            ev = (q.size() > 0) && (cyc - q[0].c == LAT);
            chk("valid_a", yv_a, ev);
            chk("valid_b", yv_b, ev);
            if (ev) begin
                e = q.pop_front();
                chk("y_a", y_a, e.y);
                chk("ovf_a", ovf_a, (e.y > 9999) ? 1 : 0);
                chk("y_b", y_b, e.y);
                chk("ovf_b", ovf_b, (e.y > 99) ? 1 : 0);
                disp_a = mk_disp(e.y, 4);
                disp_b = mk_disp(e.y, 2);
            end
            chk("busy", busy_a, (q.size() != 0) ? 1 : 0);
            chk("ready", rdy_a, (q.size() == 0) ? 1 : 0);
            chk("cs_a", cs_a, 1 << cs_pos);
            chk("cs_b", cs_b, 1 << (cs_pos % 2));
            chk("dig_a", dig_a, disp_a[cs_pos*4 +: 4]);
            chk("dig_b", dig_b, disp_b[(cs_pos % 2)*4 +: 4]);
            pend   = i_sample_valid && rdy_a;
            pend_s = i_sample;
            pend_m = i_mode;
        end
    end

    task automatic tick();
        @(posedge clk_1kHz);
        #1;
    endtask

    // Offer a sample and hold valid until the DUT accepts it.
    task automatic send(input int s, input bit m, input bit tog);
        bit rdy;
        int n;
        i_sample       = 3'(s);
        i_mode         = m;
        i_sample_valid = 1'b1;
        n = 0;
        do begin
            rdy = rdy_a;
            tick();
            n++;
        end while (!rdy && n < 100);
        if (!rdy) chk("accept_timeout", 0, 1);
        i_sample_valid = 1'b0;
        if (tog) i_mode = ~m;
    endtask

    initial begin
        int n;
        i_rst_n        = 1'b0;
        i_mode         = 1'b0;
        i_sample_valid = 1'b0;
        i_sample       = 3'd0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        chk("reset_y", y_a, 0);
        chk("reset_ovf", ovf_a, 0);
        chk("reset_ready", rdy_a, 1);
        chk("reset_busy", busy_a, 0);
        chk("reset_cs", cs_a, 1);
        chk("reset_digit", dig_a, 0);

        send(1, 1'b0, 1'b0);
        repeat (8) send(0, 1'b0, 1'b0);
        repeat (10) send(7, 1'b0, 1'b0);
        repeat (8) send(5, 1'b1, 1'b1);
        repeat (6) send(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);

        send(3, 1'b0, 1'b0);
        repeat (11) tick();
        i_rst_n = 1'b0;
        repeat (2) tick();
        i_rst_n = 1'b1;
        chk("abort_cs", cs_a, 1);
        chk("abort_digit", dig_a, 0);
        repeat (3) tick();

        send(1, 1'b0, 1'b0);
        repeat (8) send(0, 1'b0, 1'b0);

        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain", q.size(), 0);
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
